// File: rtl/fifo_rd_ctrl_pkg.sv
// Pointer helpers shared by the read- and write-domain FIFO controllers.
// Functions work on zero-extended pointers of any width up to 32 bits.
package fifo_rd_ctrl_pkg;

  localparam logic [31:0] PTR_RST = '0;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits stay zero, so the result is width-agnostic.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into clk.
// Latency 2 clk edges; no backpressure.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta_q;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Dual-clock FIFO read controller: 3 rd_clk edges from write pointer to valid_o.
// Registered output stage; holds data and pointers while valid_o && !ready_i.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [PTR_WIDTH:0]    g_wptr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [PTR_WIDTH:0]    b_rptr_o,
  output logic [PTR_WIDTH:0]    g_rptr_o,
  output logic                  empty_o,
  output logic [PTR_WIDTH:0]    rd_level_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int PW = PTR_WIDTH + 1;

  if (DEPTH != (1 << PTR_WIDTH)) begin : g_bad_depth
    $error("fifo_rd_ctrl: DEPTH must equal 2**PTR_WIDTH");
  end

  logic [PW-1:0]         wq2;
  logic [PW-1:0]         wbin;
  logic [PW-1:0]         b_rptr_q, b_rptr_d;
  logic [PW-1:0]         g_rptr_q, g_rptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  pop;

  sync_2ff #(.WIDTH(PW)) u_wptr_sync (
    .clk   (rd_clk),
    .rst_n (rd_rst_n),
    .d_i   (g_wptr_i),
    .q_o   (wq2)
  );

  assign wbin    = PW'(gray2bin(32'(wq2)));
  assign empty_o = (g_rptr_q == wq2);
  assign pop     = !empty_o && (!valid_q || ready_i);

  always_comb begin
    b_rptr_d = b_rptr_q;
    g_rptr_d = g_rptr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    if (pop) begin
      data_d   = mem_data_i;
      valid_d  = 1'b1;
      b_rptr_d = b_rptr_q + PW'(1);
      g_rptr_d = PW'(bin2gray(32'(b_rptr_d)));
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Gray pointer is registered alongside the binary one so the write side never sees it early.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      b_rptr_q <= PW'(PTR_RST);
      g_rptr_q <= PW'(PTR_RST);
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      b_rptr_q <= b_rptr_d;
      g_rptr_q <= g_rptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign b_rptr_o   = b_rptr_q;
  assign g_rptr_o   = g_rptr_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign rd_level_o = wbin - b_rptr_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomised bench for fifo_rd_ctrl against a sequence-count reference model.
module tb_fifo_rd_ctrl;

  logic       rd_clk = 1'b0;
  logic       rd_rst_n;
  logic [3:0] g_wptr_i;
  logic [7:0] mem_data_i;
  logic [3:0] b_rptr_o;
  logic [3:0] g_rptr_o;
  logic       empty_o;
  logic [3:0] rd_level_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_ctrl #(.DEPTH(8), .DATA_WIDTH(8), .PTR_WIDTH(3)) dut (
    .rd_clk     (rd_clk),
    .rd_rst_n   (rd_rst_n),
    .g_wptr_i   (g_wptr_i),
    .mem_data_i (mem_data_i),
    .b_rptr_o   (b_rptr_o),
    .g_rptr_o   (g_rptr_o),
    .empty_o    (empty_o),
    .rd_level_o (rd_level_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  // Memory model with combinational read port
  logic [7:0] mem [0:7];
  assign mem_data_i = mem[b_rptr_o[2:0]];

  int total = 0;
  int bad   = 0;

  // Reference: words by sequence number, write count, pop count, sync pipeline of counts
  logic [7:0] words [0:1023];
  int         wcnt, rp, s1, vis;
  bit         mvld;
  logic [7:0] mdat;
  logic [3:0] g_prev;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] gray4(input int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic push(input logic [7:0] v);
    if (wcnt - rp < 8) begin
      mem[wcnt[2:0]] = v;
      words[wcnt]    = v;
      wcnt++;
      g_wptr_i = gray4(wcnt);
    end
  endtask

  task automatic cycle(input bit rdy);
    int avail;
    bit pop;
    ready_i = rdy;
    avail   = vis - rp;
    pop     = (avail > 0) && (!mvld || rdy);
    @(posedge rd_clk);
    if (pop) begin
      mdat = words[rp];
      mvld = 1'b1;
      rp++;
    end else if (mvld && rdy) begin
      mvld = 1'b0;
    end
    vis = s1;
    s1  = wcnt;
    #1;
    chk("empty",  32'(empty_o),    32'(vis == rp));
    chk("level",  32'(rd_level_o), 32'(vis - rp));
    chk("valid",  32'(valid_o),    32'(mvld));
    chk("data",   32'(data_o),     32'(mdat));
    chk("b_rptr", 32'(b_rptr_o),   32'(rp % 16));
    chk("g_rptr", 32'(g_rptr_o),   32'(gray4(rp)));
    chk("g_step", 32'($countones(g_rptr_o ^ g_prev)), pop ? 32'd1 : 32'd0);
    g_prev = g_rptr_o;
  endtask

  task automatic do_reset(input string tag);
    rd_rst_n = 1'b0;
    g_wptr_i = '0;
    ready_i  = 1'b0;
    wcnt = 0; rp = 0; s1 = 0; vis = 0;
    mvld = 1'b0; mdat = '0; g_prev = '0;
    #1;
    chk({tag, "_b"},     32'(b_rptr_o),   32'd0);
    chk({tag, "_g"},     32'(g_rptr_o),   32'd0);
    chk({tag, "_empty"}, 32'(empty_o),    32'd1);
    chk({tag, "_valid"}, 32'(valid_o),    32'd0);
    chk({tag, "_level"}, 32'(rd_level_o), 32'd0);
    chk({tag, "_data"},  32'(data_o),     32'd0);
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
  endtask

  initial begin
    int sent;
    int start;
    rd_rst_n = 1'b1;
    g_wptr_i = '0;
    ready_i  = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    #2;
    do_reset("rst");
    repeat (2) cycle(1'b0);

    // Single word held, then accepted
    push(8'hA5);
    cycle(1'b0);
    chk("single_e1_empty", 32'(empty_o), 32'd1);
    cycle(1'b0);
    chk("single_e2_empty", 32'(empty_o), 32'd0);
    cycle(1'b0);
    chk("single_e3_valid", 32'(valid_o), 32'd1);
    chk("single_e3_data",  32'(data_o),  32'hA5);
    repeat (2) cycle(1'b0);
    chk("single_held",     32'(data_o),  32'hA5);
    cycle(1'b1);
    chk("single_accept",   32'(valid_o), 32'd0);

    // Full-rate burst from a clean reset
    @(posedge rd_clk); #1;
    do_reset("rst2");
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    repeat (11) cycle(1'b1);
    chk("burst_b", 32'(b_rptr_o), 32'd8);
    chk("burst_g", 32'(g_rptr_o), 32'hC);
    cycle(1'b1);

    // Backpressure with ready pattern 1,0,0,1
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    for (int i = 0; i < 32; i++) cycle(i % 4 == 0 || i % 4 == 3);

    // Stream 20 words across the pointer wrap
    sent = 0;
    for (int i = 0; i < 60; i++) begin
      if (sent < 20 && wcnt - rp < 8) begin
        push(8'h40 + 8'(sent));
        sent++;
      end
      cycle(1'b1);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) push(8'($urandom));
      cycle(1'($urandom_range(0, 1)));
    end
    repeat (20) cycle(1'b1);

    // Reset after 3 of 8 words
    start = rp;
    sent  = 0;
    for (int i = 0; i < 30 && rp < start + 3; i++) begin
      if (sent < 8) begin
        push(8'h80 + 8'(sent));
        sent++;
      end
      cycle(1'b1);
    end
    chk("mid_reach", 32'(rp - start), 32'd3);
    do_reset("rst_mid");
    repeat (6) cycle(1'b1);
    chk("mid_idle_valid", 32'(valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
